traffic_interval_timer: RTL
===========================

# traffic_interval_timer

Interval timer that answers the traffic-light controller's timer requests. It receives `startTimer` and `timeParameter` from the controller and returns a one-cycle `expired` pulse once the selected interval has elapsed. Intervals are counted in seconds, derived from the system clock by an internal prescaler. The three interval lengths (base, extended, yellow) live in registers that the `reprogram` port can rewrite at run time.

## Interface
Parameters:
- `CLK_DIV`, 4: clock cycles per one-second tick (≥2).
- `WIDTH`, 4: width of interval values and the remaining counter.
- `BASE_DEFAULT`, 6: reset value of the base interval, in seconds.
- `EXT_DEFAULT`, 3: reset value of the extended interval, in seconds.
- `YEL_DEFAULT`, 2: reset value of the yellow interval, in seconds.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `startTimer`  in  1  start/restart request, sampled each edge.
- `timeParameter`  in  2  interval select: 00 base, 01 extended, 10 yellow, 11 base.
- `reprogram`  in  1  write strobe for the interval registers.
- `selector`  in  2  write target: 00 base, 01 extended, 10 yellow, 11 restore all three defaults.
- `timeValue`  in  WIDTH  new interval in seconds.
- `expired`  out  1  one-cycle pulse when the interval completes.
- `busy`  out  1  high while an interval is running.
- `remaining`  out  WIDTH  seconds left in the running interval; 0 when idle.

## Operation
- States: IDLE, RUN.
- Reset (async, `reset`=0):
  - State is IDLE; the prescaler, `remaining`, `expired` and `busy` are all 0.
  - The interval registers take their `*_DEFAULT` values.
- Start:
  - Applies when `startTimer`=1 at an edge, in any state.
  - Loads `remaining` with the selected register, clears the prescaler and enters RUN.
  - A start in RUN is a retrigger: the interval restarts from the full value.
- RUN:
  - The prescaler counts 0..`CLK_DIV`-1. A tick occurs when it equals `CLK_DIV`-1; it then wraps to 0.
  - On a tick with `remaining`>1: decrement `remaining`.
  - On a tick with `remaining`==1: set `remaining` to 0, return to IDLE and register `expired`=1 for exactly one cycle.
- Zero interval: a stored value of 0 is loaded as 1, so the minimum interval is one second.
- Simultaneous events:
  - Start on the same edge as the final tick: the start wins. No `expired` pulse; the new interval loads.
  - Reprogram while running: the register updates, but the running count is unaffected.
  - Reprogram and start on the same edge: the start loads the old value, and the register then holds the new one.
- Reset mid-operation aborts immediately. No `expired` pulse follows.
- `busy` is 1 exactly in RUN. `expired` is never 1 while `busy` is 1.

## Timing
- Start sampled at edge E0 with selected value N: ticks fall at E0+k·`CLK_DIV`; `expired` rises at edge E0+N·`CLK_DIV` and falls at the next edge.
- `remaining` reads N after E0 and decrements at each tick edge.
- Reprogram writes take effect at the sampling edge. A start on the next edge sees the new value.
- Arithmetic is unsigned at `WIDTH` bits; `remaining` never wraps below 0.

## Configuration
- Macro: `TIMER_REPROGRAM_EN`.
- Defined: the interval registers are writable through `reprogram`/`selector`/`timeValue` as described above.
- Undefined:
  - The intervals are constants equal to the `*_DEFAULT` parameters.
  - `reprogram`, `selector` and `timeValue` are ignored (ports remain present).
  - Timing is otherwise identical.

## Test plan
All scenarios use the default parameters.
- Reset then idle: hold `reset`=0 for 3 cycles and release → `expired`=0, `busy`=0, `remaining`=0 for 40 cycles with no start.
- Base interval: `startTimer`=1 for 1 cycle at edge 0 with `timeParameter`=00 → `remaining`=6 after edge 0; `expired` high only during the cycle starting at edge 24; `busy` falls at edge 24.
- Yellow and extended intervals: `timeParameter`=10 → `expired` at edge 8; `timeParameter`=01 → `expired` at edge 12.
- Retrigger: start (yellow) at edge 0, start again (base) at edge 6 → no pulse at edge 8; `expired` at edge 30.
- Reprogram (macro defined):
  - `reprogram`=1, `selector`=00, `timeValue`=2 → a later base start expires after 8 cycles.
  - `selector`=11 → base reverts to 6 (24 cycles).
  - `timeValue`=0 → interval of 4 cycles.
- Mid-run abort: start base, assert `reset`=0 at edge 10 → outputs are 0 immediately, and no `expired` pulse follows release.

Source files
------------

// File: rtl/traffic_interval_timer_if.sv
// Controller-to-timer bundle: start/select request, interval reprogramming,
// and the timer's status outputs.
interface traffic_interval_timer_if #(
   parameter int WIDTH = 4
);
   logic             startTimer;
   logic [1:0]       timeParameter;
   logic             reprogram;
   logic [1:0]       selector;
   logic [WIDTH-1:0] timeValue;
   logic             expired;
   logic             busy;
   logic [WIDTH-1:0] remaining;

   modport master (
      output startTimer, timeParameter, reprogram, selector, timeValue,
      input  expired, busy, remaining
   );

   modport slave (
      input  startTimer, timeParameter, reprogram, selector, timeValue,
      output expired, busy, remaining
   );
endinterface

// File: rtl/traffic_interval_timer.sv
// Seconds-based interval timer for the traffic-light controller.
// Optional macro TIMER_REPROGRAM_EN makes the three interval registers writable.
module traffic_interval_timer #(
   parameter int CLK_DIV      = 4,
   parameter int WIDTH        = 4,
   parameter int BASE_DEFAULT = 6,
   parameter int EXT_DEFAULT  = 3,
   parameter int YEL_DEFAULT  = 2
) (
   input logic clk,
   input logic reset,
   traffic_interval_timer_if.slave tif
);
   localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESCALE_MAX = PW'(CLK_DIV - 1);

   typedef enum logic {IDLE, RUN} stateT;

   stateT            stateReg;
   logic [PW-1:0]    prescaleReg;
   logic [WIDTH-1:0] remainingReg;
   logic             expiredReg;
   logic [WIDTH-1:0] baseVal, extVal, yelVal;
   logic [WIDTH-1:0] selectedVal, loadVal;

`ifdef TIMER_REPROGRAM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         baseVal <= WIDTH'(BASE_DEFAULT);
         extVal  <= WIDTH'(EXT_DEFAULT);
         yelVal  <= WIDTH'(YEL_DEFAULT);
      end else if (tif.reprogram) begin
         case (tif.selector)
            2'b00:   baseVal <= tif.timeValue;
            2'b01:   extVal  <= tif.timeValue;
            2'b10:   yelVal  <= tif.timeValue;
            default: begin
               baseVal <= WIDTH'(BASE_DEFAULT);
               extVal  <= WIDTH'(EXT_DEFAULT);
               yelVal  <= WIDTH'(YEL_DEFAULT);
            end
         endcase
      end
   end
`else
   assign baseVal = WIDTH'(BASE_DEFAULT);
   assign extVal  = WIDTH'(EXT_DEFAULT);
   assign yelVal  = WIDTH'(YEL_DEFAULT);
   logic unusedInputs;
   assign unusedInputs = ^{tif.reprogram, tif.selector, tif.timeValue};
`endif

   always_comb begin
      selectedVal = baseVal;
      case (tif.timeParameter)
         2'b01:   selectedVal = extVal;
         2'b10:   selectedVal = yelVal;
         default: selectedVal = baseVal;
      endcase
   end

   // A stored zero still runs for one full second.
   assign loadVal = (selectedVal == '0) ? WIDTH'(1) : selectedVal;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateReg     <= IDLE;
         prescaleReg  <= '0;
         remainingReg <= '0;
         expiredReg   <= 1'b0;
      end else begin
         expiredReg <= 1'b0;
         if (tif.startTimer) begin
            stateReg     <= RUN;
            prescaleReg  <= '0;
            remainingReg <= loadVal;
         end else if (stateReg == RUN) begin
            if (prescaleReg == PRESCALE_MAX) begin
               prescaleReg <= '0;
               if (remainingReg > WIDTH'(1)) begin
                  remainingReg <= remainingReg - WIDTH'(1);
               end else begin
                  remainingReg <= '0;
                  stateReg     <= IDLE;
                  expiredReg   <= 1'b1;
               end
            end else begin
               prescaleReg <= prescaleReg + PW'(1);
            end
         end
      end
   end

   assign tif.expired   = expiredReg;
   assign tif.busy      = (stateReg == RUN);
   assign tif.remaining = remainingReg;
endmodule
